dmem_arbiter: RTL

- Shares the single data-memory port between the instruction fetch unit (IFU, read-only, word) and the load/store unit (LSU, read/write, MemOp-encoded).
- Accepts one request at a time, with round-robin arbitration, and drives the memory-side valid/ready request channel.
- Routes the response back to the winner. For LSU reads it applies the sign/zero extension the MemOp encoding specifies.
- Flags misaligned or illegal accesses and memory timeouts.

---
 rtl/dmem_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory request/response port between the
// instruction fetch unit and the load/store unit. One transaction is in
// flight at a time. Round-robin arbitration picks the requester. Illegal
// accesses and memory timeouts are answered with an error response.
module dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [2:0]  lsu_memop,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  typedef enum logic {SRC_IFU, SRC_LSU} src_t;

  localparam logic [2:0] OP_WORD = 3'b010;

  // Alignment and encoding rules; unsigned loads have no store form.
  function automatic logic access_legal(input logic [1:0] addr_lo, input logic wen,
                                        input logic [2:0] memop);
    logic ok;
    ok = 1'b0;
    case (memop)
      3'b010:  ok = (addr_lo == 2'b00);
      3'b001:  ok = ~addr_lo[0];
      3'b101:  ok = ~addr_lo[0] & ~wen;
      3'b000:  ok = 1'b1;
      3'b100:  ok = ~wen;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [2:0] memop);
    logic [7:0] m;
    case (memop)
      3'b010:         m = 8'h0F;
      3'b001, 3'b101: m = 8'h03;
      3'b000, 3'b100: m = 8'h01;
      default:        m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] memop, input logic [31:0] d);
    logic [31:0] r;
    case (memop)
      3'b010:  r = d;
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b101:  r = {16'h0000, d[15:0]};
      3'b100:  r = {24'h000000, d[7:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t      state, state_nxt;
  src_t        last_grant, winner, rsp_src, buf_src;
  logic        grant;
  logic [31:0] sel_addr, sel_wdata, buf_addr, buf_wdata, ok_data, rsp_data;
  logic        sel_wen, sel_legal, buf_wen, rsp_fire, rsp_err, mem_done, timeout_hit;
  logic [2:0]  sel_memop, buf_memop;
  logic [7:0]  buf_wmask;
  logic [CNT_W-1:0] cnt;

  // Round-robin pick among valid requesters; only offered while idle and out of reset.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant  = 1'b0;
    winner = SRC_IFU;
    if (rst && state == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant  = 1'b1;
        winner = (last_grant == SRC_LSU) ? SRC_IFU : SRC_LSU;
      end else if (ifu_req_valid) begin
        grant  = 1'b1;
        winner = SRC_IFU;
      end else if (lsu_req_valid) begin
        grant  = 1'b1;
        winner = SRC_LSU;
      end
    end
  end

  assign ifu_req_ready = grant && (winner == SRC_IFU);
  assign lsu_req_ready = grant && (winner == SRC_LSU);

  // The IFU is treated as a word load so one legality check covers both sources.
  assign sel_addr  = (winner == SRC_LSU) ? lsu_addr : ifu_addr;
  assign sel_wen   = (winner == SRC_LSU) && lsu_wen;
  assign sel_memop = (winner == SRC_LSU) ? lsu_memop : OP_WORD;
  assign sel_wdata = sel_wen ? lsu_wdata : '0;
  assign sel_legal = access_legal(sel_addr[1:0], sel_wen, sel_memop);

  assign mem_done    = mem_rsp_valid && ((state == S_REQ && mem_req_ready) || state == S_WAIT);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ok_data     = (buf_src == SRC_IFU) ? mem_rdata :
                       (buf_wen ? '0 : load_extend(buf_memop, mem_rdata));

  // Next state plus the response that gets registered when entering RESP.
  always_comb begin
    state_nxt = state;
    rsp_fire  = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    rsp_src   = buf_src;
    case (state)
      S_IDLE: begin
        if (grant) begin
          rsp_src = winner;
          if (sel_legal) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_RESP;
            rsp_fire  = 1'b1;
            rsp_err   = 1'b1;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (mem_done) begin
          state_nxt = S_RESP;
          rsp_fire  = 1'b1;
          rsp_data  = ok_data;
        end else if (timeout_hit) begin
          state_nxt = S_RESP;
          rsp_fire  = 1'b1;
          rsp_err   = 1'b1;
        end else if (state == S_REQ && mem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Request buffer, arbitration history, timeout counter and registered responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the buffer and response data are reset because they drive outputs that must read 0.
      last_grant    <= SRC_LSU;
      buf_src       <= SRC_IFU;
      buf_addr      <= '0;
      buf_wen       <= 1'b0;
      buf_memop     <= '0;
      buf_wmask     <= '0;
      buf_wdata     <= '0;
      cnt           <= '0;
      ifu_rsp_valid <= 1'b0;
      ifu_rdata     <= '0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rdata     <= '0;
      lsu_rsp_err   <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      if (grant) begin
        last_grant <= winner;
        buf_src    <= winner;
        buf_addr   <= sel_addr;
        buf_wen    <= sel_wen;
        buf_memop  <= sel_memop;
        buf_wmask  <= byte_mask(sel_memop);
        buf_wdata  <= sel_wdata;
      end
      if (state == S_REQ || state == S_WAIT) cnt <= cnt + CNT_W'(1);
      else                                   cnt <= '0;
      if (rsp_fire) begin
        if (rsp_src == SRC_IFU) begin
          ifu_rsp_valid <= 1'b1;
          ifu_rdata     <= rsp_data;
          ifu_rsp_err   <= rsp_err;
        end else begin
          lsu_rsp_valid <= 1'b1;
          lsu_rdata     <= rsp_data;
          lsu_rsp_err   <= rsp_err;
        end
      end
    end
  end

  assign mem_req_valid = (state == S_REQ);
  assign mem_wen       = (state == S_REQ) && buf_wen;
  assign mem_addr      = buf_addr;
  assign mem_wmask     = buf_wmask;
  assign mem_wdata     = buf_wdata;

endmodule
